serial_subtractor_ctrl: RTL
===========================

# serial_subtractor_ctrl

Bit-serial multi-bit subtractor controller that computes `a - b` one bit per clock, LSB first, on a single shared full-subtract cell built from two half-subtract stages. It accepts a start request, latches operands, steps a bit counter, and carries the borrow between bits in a register. It presents a registered difference, a final borrow and a one-cycle `done` pulse. It sits between the lab's combinational subtractor cells and any sequencing logic that needs wide subtraction without a wide ripple chain.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Legal range is 1 to 32.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `start`  in  1  request to begin a subtraction; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; latched on the accepted start.
- `b`  in  WIDTH  subtrahend; latched on the accepted start.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when the result is valid.
- `diff`  out  WIDTH  registered difference.
- `borrow`  out  1  registered final borrow-out; 1 when `a < b` (unsigned).

## Operation
- **States:**
  - IDLE: reset state.
  - RUN: one bit processed per cycle.
  - DONE: lasts exactly one cycle.
- **IDLE:**
  - `start`=1 latches `a` and `b` into operand shift registers.
  - Clears the bit counter, borrow register, `diff` and `borrow`.
  - Next state is RUN.
- **RUN, per cycle at bit index i (counter value):**
  - Stage 1: `d1 = a_i ^ b_i`, `b1 = ~a_i & b_i`.
  - Stage 2: `diff_i = d1 ^ bin`, `b2 = ~d1 & bin`.
  - `bout = b1 | b2`, stored as the next `bin`. `bin` is 0 at bit 0.
  - `diff[i]` is written. The counter increments.
  - When i = WIDTH-1: `borrow` is loaded with `bout`, next state is DONE.
- **DONE:**
  - `done`=1 for this cycle.
  - With `start`=1, the new operands are accepted exactly as from IDLE and the next state is RUN (back-to-back operation).
  - Otherwise the next state is IDLE.
- **Start while busy:** `start` is ignored in RUN. Operands are not relatched and the sequence is not restarted.
- **Result hold:** `diff` and `borrow` hold their values after DONE until the next accepted start. During RUN, `diff` shows partial results and is not valid.
- **Arithmetic:** unsigned modulo 2^WIDTH. `diff = (a - b) mod 2^WIDTH`, `borrow = (a < b)`.

## Timing
- **Reset:** `rst_n`=0 at an edge forces IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0, counter 0 and the borrow register 0. Reset mid-RUN aborts the operation and no `done` is produced.
- **Latency:** `start` is sampled at edge E0.
  - `busy` is high after E0.
  - Bits are processed on edges E1..E_WIDTH.
  - `busy` falls and `done` rises after E_WIDTH.
  - `done` falls after E_(WIDTH+1), unless back-to-back: then `done` falls and `busy` rises at the same edge.
- **Throughput:** one result per WIDTH+1 cycles when back-to-back.
- **Bit counter:** ceil(log2(WIDTH)) bits, minimum 1. It does not wrap within an operation.
- **WIDTH=1:** a single RUN cycle. The result equals the half-subtract truth table.

## Configuration
- `SERIAL_SUB_SAT_EN` defined:
  - Saturating mode. When the final borrow is 1, `diff` is forced to all zeros in the same edge that loads `borrow`.
  - `borrow` still reports 1.
- `SERIAL_SUB_SAT_EN` undefined:
  - Wrap-around mode. `diff` holds the modulo-2^WIDTH result.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, one-cycle `start` -> `busy` high for 8 cycles, `done` pulses in cycle 9, `diff`=0x1E, `borrow`=0.
- WIDTH=8, `a`=0x00, `b`=0x01 -> `borrow`=1. `diff`=0xFF without the macro, 0x00 with `SERIAL_SUB_SAT_EN`.
- Pulse `start` again in the 3rd RUN cycle with `a`=0xFF, `b`=0x00 -> ignored: the first result (0x1E) still completes on schedule, with no relatch.
- Pull `rst_n` low in the 5th RUN cycle -> `busy`=0, `done` never pulses, `diff`=0, `borrow`=0, state IDLE. A subsequent start completes normally.
- Hold `start`=1 continuously with `a`=0x80, `b`=0x7F then `a`=0x10, `b`=0x20 -> `done` every 9 cycles. Results in order: 0x01/0, then 0xF0/1 (0x00/1 with saturation).
- WIDTH=1, all four `a`,`b` combinations -> `diff`/`borrow` = 0/0, 1/1, 1/0, 0/0, each after one RUN cycle.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b controller: one full-subtract step per clock, LSB first.
// Optional macro SERIAL_SUB_SAT_EN clamps diff to zero on a final borrow.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             bin;

  // Shared full-subtract cell: two half-subtract stages on the current LSBs.
  logic d1, b1, diff_bit, b2, bout;

  always_comb begin
    d1       = a_sr[0] ^ b_sr[0];
    b1       = ~a_sr[0] & b_sr[0];
    diff_bit = d1 ^ bin;
    b2       = ~d1 & bin;
    bout     = b1 | b2;
  end

  // Difference bits enter at the MSB and shift down, so after WIDTH steps
  // bit i sits in diff[i] without a variable-index write.
  logic [WIDTH-1:0] diff_next;
  assign diff_next = (diff >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of state, cnt and bin regardless of statement order.
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            a_sr   <= a;
            b_sr   <= b;
            cnt    <= '0;
            bin    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bin  <= bout;
          diff <= diff_next;
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            borrow <= bout;
`ifdef SERIAL_SUB_SAT_EN
            if (bout) diff <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
